// File: rtl/perif_arbiter.sv
// perif_arbiter: two-requester four-phase arbiter in front of one shared
// peripheral. Round-robin on simultaneous requests, GRANT-phase timeout.
// Optional macro PERIF_ARBITER_ACK_SYNC_EN: when defined, perif_ack passes
// through a two-flop synchronizer before the FSM sees it.
module perif_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send0,
   input  logic       data0,
   output logic       ack0,
   input  logic       send1,
   input  logic       data1,
   output logic       ack1,
   output logic       perif_send,
   output logic       perif_data,
   input  logic       perif_ack,
   output logic [1:0] grant,
   output logic       timeout_err
);

   typedef enum logic [1:0] {IDLE, GRANT, RET_ACK, RELEASE} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic       ptr, ptr_nx;
   logic       ack0_nx, ack1_nx, psend_nx, pdata_nx, terr_nx;
   logic [1:0] grant_nx;
   logic       ack_s;
   logic       own, own_send, own_data, pick;

   // owner index follows the registered one-hot grant
   assign own      = grant[1];
   assign own_send = own ? send1 : send0;
   assign own_data = own ? data1 : data0;
   // on a tie the pointer decides, otherwise whoever is asking
   assign pick     = (send0 & send1) ? ptr : send1;

`ifdef PERIF_ARBITER_ACK_SYNC_EN
   logic [1:0] ack_sync;

   // two-flop synchronizer on the peripheral acknowledge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ack_sync <= 2'b00;
      else     ack_sync <= {ack_sync[0], perif_ack};
   end

   assign ack_s = ack_sync[1];
`else
   assign ack_s = perif_ack;
`endif

   // state register plus registered outputs, counter and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         ptr         <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         perif_send  <= 1'b0;
         perif_data  <= 1'b0;
         grant       <= 2'b00;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         ptr         <= ptr_nx;
         ack0        <= ack0_nx;
         ack1        <= ack1_nx;
         perif_send  <= psend_nx;
         perif_data  <= pdata_nx;
         grant       <= grant_nx;
         timeout_err <= terr_nx;
      end
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (send0 | send1)    state_nx = GRANT;
         GRANT:   if (ack_s)            state_nx = RET_ACK;
                  else if (cnt == TO_LAST) state_nx = RELEASE;
         RET_ACK: if (!own_send)        state_nx = RELEASE;
         RELEASE: if (!ack_s)           state_nx = IDLE;
         default:                       state_nx = IDLE;
      endcase
   end

   // next values of the registered outputs, counter and pointer
   always_comb begin
      cnt_nx   = cnt;
      ptr_nx   = ptr;
      ack0_nx  = ack0;
      ack1_nx  = ack1;
      psend_nx = perif_send;
      pdata_nx = perif_data;
      grant_nx = grant;
      terr_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (send0 | send1) begin
               grant_nx = pick ? 2'b10 : 2'b01;
               psend_nx = 1'b1;
               pdata_nx = pick ? data1 : data0;
               cnt_nx   = 8'd0;
            end
         end
         GRANT: begin
            pdata_nx = own_data;
            if (ack_s) begin
               ack0_nx = ~own;
               ack1_nx = own;
            end else begin
               cnt_nx = cnt + 8'd1;
               // abort: drop the peripheral request, never ack the requester
               if (cnt == TO_LAST) begin
                  psend_nx = 1'b0;
                  terr_nx  = 1'b1;
               end
            end
         end
         RET_ACK: begin
            if (!own_send) psend_nx = 1'b0;
         end
         RELEASE: begin
            if (!ack_s) begin
               ack0_nx  = 1'b0;
               ack1_nx  = 1'b0;
               grant_nx = 2'b00;
               pdata_nx = 1'b0;
               cnt_nx   = 8'd0;
               ptr_nx   = ~own;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/perif_arbiter.md
PERIF_ARBITER -- requirements
Module: perif_arbiter

Interface
REQ-001 SHALL accept parameter TIMEOUT, default 16, meaning the number of cycles GRANT waits for peripheral ack before aborting (legal range 2..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port send0  input  1  requester 0 transfer request (four-phase).
REQ-005 SHALL have port data0  input  1  requester 0 data bit, stable while send0=1.
REQ-006 SHALL have port ack0  output  1  acknowledge to requester 0.
REQ-007 SHALL have port send1  input  1  requester 1 transfer request.
REQ-008 SHALL have port data1  input  1  requester 1 data bit.
REQ-009 SHALL have port ack1  output  1  acknowledge to requester 1.
REQ-010 SHALL have port perif_send  output  1  request to the shared peripheral.
REQ-011 SHALL have port perif_data  output  1  data bit to the peripheral.
REQ-012 SHALL have port perif_ack  input  1  peripheral acknowledge.
REQ-013 SHALL have port grant  output  2  one-hot owner: bit0 = requester 0, bit1 = requester 1; 2'b00 when idle.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse on an aborted transfer.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, RET_ACK, RELEASE; all outputs registered.
REQ-016 IDLE: any sendN=1 -> next edge: grant set, perif_send=1, perif_data=dataN, state GRANT.
REQ-017 Both send0 and send1 high in IDLE: SHALL grant the requester not served last (round-robin pointer); pointer resets to favour requester 0.
REQ-018 GRANT: perif_data SHALL track the granted dataN; on sampled perif_ack=1 -> ackN=1, state RET_ACK.
REQ-019 RET_ACK: on granted sendN=0 -> perif_send=0, state RELEASE.
REQ-020 RELEASE: on sampled perif_ack=0 -> ackN=0, grant=00, pointer toggles to the other requester, state IDLE.
REQ-021 The ungranted requester's ack SHALL stay 0; its send SHALL be held pending, never dropped.
REQ-022 GRANT cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT with no sampled ack -> perif_send=0, timeout_err pulse, state RELEASE, ackN never asserted.
REQ-023 A requester dropping sendN in GRANT before ack SHALL be ignored until ack; the transfer completes normally.
REQ-024 Minimum transfer with an immediately responding peripheral (no sync): 4 cycles IDLE->IDLE.
REQ-025 Back-to-back: a new grant SHALL NOT issue in the same cycle RELEASE exits; earliest is the following edge.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, ack0=ack1=0, perif_send=0, perif_data=0, grant=00, timeout_err=0, counter=0, pointer=requester 0, synchronizer flops=0.
REQ-027 Reset mid-transfer SHALL abandon the transfer with no error pulse; after release, arbitration restarts from IDLE.

Configuration
REQ-028 Macro PERIF_ARBITER_ACK_SYNC_EN defined: perif_ack SHALL pass through a two-flop synchronizer before the FSM (+2 cycles per ack edge; timeout counts sync'd ack).
REQ-029 Macro undefined: perif_ack SHALL be sampled directly by the FSM.

Verification
REQ-030 Single request: send0=1,data0=1, peripheral acks 1 cycle after perif_send -> grant=01, perif_data=1, ack0 rises, full four-phase completes, grant=00.
REQ-031 Simultaneous send0=send1=1 from reset -> requester 0 served first, then requester 1 (grant 01 then 10); ack1 stays 0 during the first transfer.
REQ-032 Peripheral never acks, TIMEOUT=4 -> perif_send drops after 4 GRANT cycles, timeout_err one pulse, ack0 never 1, return to IDLE.
REQ-033 rst pulsed while in RET_ACK -> all outputs 0 within the reset cycle without waiting for clk; later send1=1 is granted normally.
REQ-034 With PERIF_ARBITER_ACK_SYNC_EN, repeat REQ-030 -> ack0 rises exactly 2 cycles later than without the macro.
